instr_dec: RTL and testbench
============================

// Module: instr_dec
// PURPOSE
//  MSP430 instruction decoder. Registers the fetched instruction word from the memory data bus into an
//  internal instruction register (IR). Decodes the IR combinationally into format, register addresses,
//  addressing modes, an immediate/constant word and PC/SP/SR mux selects. Sits between the MDB and the
//  control unit / register file.
// PARAMETERS
//  none
// PORTS
//  clk      in   1   system clock; all state changes on rising edge
//  rst      in   1   synchronous, active-high reset
//  CTL_SEL  in   1   0: load IR from MDB_out on this edge; 1: hold IR (multi-cycle execute)
//  MDB_out  in   16  instruction word from memory data bus
//  FORMAT   out  2   00 Fmt I double-operand, 01 Fmt II single-operand, 10 Fmt III jump, 11 invalid
//  reg_SA   out  4   source register address
//  reg_DA   out  4   destination register address
//  AdAs     out  3   {Ad, As[1:0]} addressing modes
//  reg_Din  out  16  constant-generator value or jump byte offset
//  MPC      out  3   PC mux select
//  MSP      out  2   SP mux select
//  MSR      out  1   1 = instruction updates SR flags
// BEHAVIOUR
//  - IR: rst=1 -> 0x0000 (rst has priority); else CTL_SEL=0 -> IR<=MDB_out; else hold.
//  - All outputs are pure combinational functions of IR; 1-cycle latency from MDB_out to outputs.
//  - Decode order:
//    - IR[15:12]>=4 -> Fmt I.
//    - IR[15:13]==001 -> Fmt III.
//    - IR[15:10]==000100 with IR[9:7]!=111 -> Fmt II.
//    - Anything else -> FORMAT=11, all other outputs 0.
//  - Fmt I: reg_SA=IR[11:8], reg_DA=IR[3:0], AdAs={IR[7],IR[5:4]}.
//  - Fmt II: reg_SA=reg_DA=IR[3:0], AdAs={0,IR[5:4]}.
//  - Fmt III: reg_SA=reg_DA=0, AdAs=000.
//  - reg_Din:
//    - Fmt III: {{5{IR[9]}},IR[9:0],1'b0} (sign-extended offset x2).
//    - Constant generator, source R3: As 00/01/10/11 -> 0x0000/0x0001/0x0002/0xFFFF.
//    - Constant generator, source R2: As 10/11 -> 0x0004/0x0008.
//    - Otherwise 0.
//  - MSR=1:
//    - Fmt I opcodes ADD,ADDC,SUBC,SUB,CMP,DADD,BIT,XOR,AND (IR[15:12]=5-B,E,F).
//    - Fmt II RRC,RRA,SXT,RETI (IR[9:7]=000,010,011,110).
//    - 0 for MOV,BIC,BIS,SWPB,PUSH,CALL, all jumps and invalid.
//  - MPC codes:
//    - 000 hold: invalid.
//    - 001 PC+2: default.
//    - 010 PC+offset: JMP, IR[12:10]=111.
//    - 011 conditional offset: other jumps; control unit tests flags.
//    - 100 load from result: Fmt I with reg_DA=0 and Ad=0; Fmt II CALL.
//    - 101 load from stack: RETI.
//  - MSP codes:
//    - 01 SP-2: PUSH, CALL.
//    - 10 SP+2: RETI.
//    - 11 load from result: Fmt I with reg_DA=1 and Ad=0.
//    - 00 otherwise.
//  - After reset: IR=0x0000 -> FORMAT=11, reg_SA=reg_DA=0, AdAs=000, reg_Din=0, MPC=000, MSP=00, MSR=0.
//  - rst asserted mid-execution (CTL_SEL=1) still clears IR on that edge.
//  - Byte/word bit IR[6] is not decoded here.
// CONFIGURATION
//  INSTR_DEC_CG_EN
//  - Defined: R2/R3 constant-generator decode onto reg_Din as above.
//  - Undefined: reg_Din carries only the Fmt III offset; 0 for Fmt I/II.
// TESTING
//  1 rst=1 one edge -> FORMAT=11, MPC=000, all other outputs 0.
//  2 CTL_SEL=0, MDB_out=0x5034 (ADD #imm,R4), one edge -> FORMAT=00, reg_SA=0, reg_DA=4, AdAs=011,
//    MSR=1, MPC=001, MSP=00.
//  3 MDB_out=0x4325 (MOV #2,R5) -> FORMAT=00, reg_SA=3, reg_DA=5, AdAs=010, MSR=0;
//    reg_Din=0x0002 with INSTR_DEC_CG_EN, 0x0000 without.
//  4 MDB_out=0x3FFF (JMP -1) -> FORMAT=10, reg_Din=0xFFFE, MPC=010.
//    MDB_out=0x2400 (JEQ +0) -> MPC=011, reg_Din=0.
//  5 Fmt II stack ops:
//    - MDB_out=0x1230 (PUSH #imm) -> FORMAT=01, MSP=01, MPC=001, MSR=0.
//    - MDB_out=0x1300 (RETI) -> MPC=101, MSP=10, MSR=1.
//  6 IR hold: load 0x4303, then CTL_SEL=1 with MDB_out changing every cycle -> outputs stay decoded from 0x4303.
//    Then set CTL_SEL=0 -> new word reflected after the next edge.

Source files
------------

// File: rtl/instr_dec.sv
// MSP430 instruction decoder: registers the fetched word into IR and decodes it
// combinationally. Define INSTR_DEC_CG_EN to decode R2/R3 constant-generator values.
module instr_dec (
  input  logic        clk,
  input  logic        rst,
  input  logic        CTL_SEL,
  input  logic [15:0] MDB_out,
  output logic [1:0]  FORMAT,
  output logic [3:0]  reg_SA,
  output logic [3:0]  reg_DA,
  output logic [2:0]  AdAs,
  output logic [15:0] reg_Din,
  output logic [2:0]  MPC,
  output logic [1:0]  MSP,
  output logic        MSR
);

  typedef enum logic [1:0] {
    FMT_I   = 2'b00,
    FMT_II  = 2'b01,
    FMT_III = 2'b10,
    FMT_BAD = 2'b11
  } fmt_t;

  typedef enum logic [2:0] {
    MPC_HOLD = 3'b000,
    MPC_INC  = 3'b001,
    MPC_JMP  = 3'b010,
    MPC_JCC  = 3'b011,
    MPC_RES  = 3'b100,
    MPC_STK  = 3'b101
  } mpc_t;

  typedef enum logic [1:0] {
    MSP_HOLD = 2'b00,
    MSP_DEC  = 2'b01,
    MSP_INC  = 2'b10,
    MSP_RES  = 2'b11
  } msp_t;

  typedef enum logic [2:0] {
    F2_RRC  = 3'b000,
    F2_SWPB = 3'b001,
    F2_RRA  = 3'b010,
    F2_SXT  = 3'b011,
    F2_PUSH = 3'b100,
    F2_CALL = 3'b101,
    F2_RETI = 3'b110
  } f2_op_t;

  logic [15:0] ir;
  logic        is_f1;
  logic        is_f2;
  logic        is_f3;
  logic        unused_bw;

  always_ff @(posedge clk) begin
    if (rst)
      ir <= '0;
    else if (!CTL_SEL)
      ir <= MDB_out;
  end

  // The byte/word bit is resolved downstream, not in this decoder.
  assign unused_bw = ir[6];

  assign is_f1 = (ir[15:12] >= 4'd4);
  assign is_f3 = (ir[15:13] == 3'b001);
  assign is_f2 = (ir[15:10] == 6'b000100) && (ir[9:7] != 3'b111);

`ifdef INSTR_DEC_CG_EN
  function automatic logic [15:0] cg_value(input logic [3:0] src, input logic [1:0] as);
    logic [15:0] v;
    v = '0;
    if (src == 4'd3) begin
      case (as)
        2'b00:   v = 16'h0000;
        2'b01:   v = 16'h0001;
        2'b10:   v = 16'h0002;
        default: v = 16'hFFFF;
      endcase
    end else if (src == 4'd2) begin
      case (as)
        2'b10:   v = 16'h0004;
        2'b11:   v = 16'h0008;
        default: v = 16'h0000;
      endcase
    end
    return v;
  endfunction
`endif

  always_comb begin
    FORMAT  = FMT_BAD;
    reg_SA  = '0;
    reg_DA  = '0;
    AdAs    = '0;
    reg_Din = '0;
    MPC     = MPC_HOLD;
    MSP     = MSP_HOLD;
    MSR     = 1'b0;

    if (is_f1) begin
      FORMAT = FMT_I;
      reg_SA = ir[11:8];
      reg_DA = ir[3:0];
      AdAs   = {ir[7], ir[5:4]};
`ifdef INSTR_DEC_CG_EN
      reg_Din = cg_value(ir[11:8], ir[5:4]);
`endif
      // MOV, BIC and BIS leave the flags untouched.
      MSR = !((ir[15:12] == 4'h4) || (ir[15:12] == 4'hC) || (ir[15:12] == 4'hD));
      MPC = ((ir[3:0] == 4'd0) && !ir[7]) ? MPC_RES : MPC_INC;
      MSP = ((ir[3:0] == 4'd1) && !ir[7]) ? MSP_RES : MSP_HOLD;
    end else if (is_f2) begin
      FORMAT = FMT_II;
      reg_SA = ir[3:0];
      reg_DA = ir[3:0];
      AdAs   = {1'b0, ir[5:4]};
`ifdef INSTR_DEC_CG_EN
      reg_Din = cg_value(ir[3:0], ir[5:4]);
`endif
      MPC = MPC_INC;
      case (ir[9:7])
        F2_RRC, F2_RRA, F2_SXT: MSR = 1'b1;
        F2_PUSH: MSP = MSP_DEC;
        F2_CALL: begin
          MSP = MSP_DEC;
          MPC = MPC_RES;
        end
        F2_RETI: begin
          MSR = 1'b1;
          MPC = MPC_STK;
          MSP = MSP_INC;
        end
        default: ;
      endcase
    end else if (is_f3) begin
      FORMAT  = FMT_III;
      reg_Din = {{5{ir[9]}}, ir[9:0], 1'b0};
      MPC     = (ir[12:10] == 3'b111) ? MPC_JMP : MPC_JCC;
    end
  end

endmodule

// File: tb/tb_instr_dec.sv
// Scoreboard bench for instr_dec: stimulus pushes expected decodes, a monitor
// pops and compares one entry per clock after the capturing edge.
module tb_instr_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CTL_SEL = 1'b0;
  logic [15:0] MDB_out = '0;
  logic [1:0]  FORMAT;
  logic [3:0]  reg_SA;
  logic [3:0]  reg_DA;
  logic [2:0]  AdAs;
  logic [15:0] reg_Din;
  logic [2:0]  MPC;
  logic [1:0]  MSP;
  logic        MSR;

  instr_dec dut (
    .clk(clk), .rst(rst), .CTL_SEL(CTL_SEL), .MDB_out(MDB_out),
    .FORMAT(FORMAT), .reg_SA(reg_SA), .reg_DA(reg_DA), .AdAs(AdAs),
    .reg_Din(reg_Din), .MPC(MPC), .MSP(MSP), .MSR(MSR)
  );

  always #5 clk = ~clk;

`ifdef INSTR_DEC_CG_EN
  localparam bit CG_EN = 1'b1;
`else
  localparam bit CG_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  fmt;
    logic [3:0]  sa;
    logic [3:0]  da;
    logic [2:0]  adas;
    logic [15:0] din;
    logic [2:0]  mpc;
    logic [1:0]  msp;
    logic        msr;
  } dec_t;

  typedef struct {
    dec_t  d;
    string name;
  } item_t;

  item_t       sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [15:0] m_ir    = '0;

  function automatic logic [15:0] cgen(input int unsigned src, input int unsigned as);
    if (!CG_EN) return 16'h0000;
    if (src == 3) begin
      if (as == 0) return 16'h0000;
      if (as == 1) return 16'h0001;
      if (as == 2) return 16'h0002;
      return 16'hFFFF;
    end
    if (src == 2 && as == 2) return 16'h0004;
    if (src == 2 && as == 3) return 16'h0008;
    return 16'h0000;
  endfunction

  // Reference decode worked out arithmetically from the instruction-set rules.
  function automatic dec_t model(input logic [15:0] w);
    dec_t e;
    int unsigned x, op, sa, da, ad, as, sub, cond;
    int off;
    x = w;
    op = x / 4096;
    e = '0;
    e.fmt = 2'b11;
    if (op >= 4) begin
      sa = (x / 256) % 16;
      da = x % 16;
      ad = (x / 128) % 2;
      as = (x / 16) % 4;
      e.fmt  = 2'b00;
      e.sa   = 4'(sa);
      e.da   = 4'(da);
      e.adas = 3'(ad * 4 + as);
      e.din  = cgen(sa, as);
      e.msr  = !(op == 4 || op == 12 || op == 13);
      e.mpc  = (da == 0 && ad == 0) ? 3'd4 : 3'd1;
      e.msp  = (da == 1 && ad == 0) ? 2'd3 : 2'd0;
    end else if (x / 8192 == 1) begin
      off = int'(x % 1024);
      if (off >= 512) off = off - 1024;
      cond  = (x / 1024) % 8;
      e.fmt = 2'b10;
      e.din = 16'(off * 2);
      e.mpc = (cond == 7) ? 3'd2 : 3'd3;
    end else if (x / 1024 == 4 && (x / 128) % 8 != 7) begin
      sub = (x / 128) % 8;
      da  = x % 16;
      as  = (x / 16) % 4;
      e.fmt  = 2'b01;
      e.sa   = 4'(da);
      e.da   = 4'(da);
      e.adas = 3'(as);
      e.din  = cgen(da, as);
      e.mpc  = 3'd1;
      case (sub)
        0, 2, 3: e.msr = 1'b1;
        4: e.msp = 2'd1;
        5: begin e.msp = 2'd1; e.mpc = 3'd4; end
        6: begin e.msr = 1'b1; e.mpc = 3'd5; e.msp = 2'd2; end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic dec_t mk(input logic [1:0] fmt, input logic [3:0] sa, input logic [3:0] da,
                              input logic [2:0] adas, input logic [15:0] din, input logic [2:0] mpc,
                              input logic [1:0] msp, input logic msr);
    return {fmt, sa, da, adas, din, mpc, msp, msr};
  endfunction

  task automatic step(input logic r, input logic c, input logic [15:0] w, input string name,
                      input bit use_exp, input dec_t exp_d);
    item_t it;
    @(negedge clk);
    rst = r;
    CTL_SEL = c;
    MDB_out = w;
    if (r) m_ir = '0;
    else if (!c) m_ir = w;
    it.name = name;
    it.d = use_exp ? exp_d : model(m_ir);
    sb.push_back(it);
  endtask

  initial begin : monitor
    item_t it;
    dec_t act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        act = {FORMAT, reg_SA, reg_DA, AdAs, reg_Din, MPC, MSP, MSR};
        n_tests++;
        if (act !== it.d) begin
          n_fail++;
          $display("FAIL %s: got fmt=%b sa=%h da=%h adas=%b din=%h mpc=%b msp=%b msr=%b, expected fmt=%b sa=%h da=%h adas=%b din=%h mpc=%b msp=%b msr=%b",
                   it.name, act.fmt, act.sa, act.da, act.adas, act.din, act.mpc, act.msp, act.msr,
                   it.d.fmt, it.d.sa, it.d.da, it.d.adas, it.d.din, it.d.mpc, it.d.msp, it.d.msr);
        end
      end
    end
  end

  initial begin : stimulus
    dec_t RST, ADD, MOV43;
    logic [15:0] w;
    logic [3:0]  hi;
    RST   = mk(2'b11, 4'd0, 4'd0, 3'b000, 16'h0000, 3'b000, 2'b00, 1'b0);
    ADD   = mk(2'b00, 4'd0, 4'd4, 3'b011, 16'h0000, 3'b001, 2'b00, 1'b1);
    MOV43 = mk(2'b00, 4'd3, 4'd3, 3'b000, 16'h0000, 3'b001, 2'b00, 1'b0);

    step(1'b1, 1'b0, 16'h5034, "reset", 1'b1, RST);
    step(1'b0, 1'b0, 16'h5034, "add_imm_r4", 1'b1, ADD);
    step(1'b0, 1'b0, 16'h4325, "mov_cg2_r5", 1'b1,
         mk(2'b00, 4'd3, 4'd5, 3'b010, CG_EN ? 16'h0002 : 16'h0000, 3'b001, 2'b00, 1'b0));
    step(1'b0, 1'b0, 16'h3FFF, "jmp_m1", 1'b1,
         mk(2'b10, 4'd0, 4'd0, 3'b000, 16'hFFFE, 3'b010, 2'b00, 1'b0));
    step(1'b0, 1'b0, 16'h2400, "jeq_0", 1'b1,
         mk(2'b10, 4'd0, 4'd0, 3'b000, 16'h0000, 3'b011, 2'b00, 1'b0));
    step(1'b0, 1'b0, 16'h1230, "push_imm", 1'b1,
         mk(2'b01, 4'd0, 4'd0, 3'b011, 16'h0000, 3'b001, 2'b01, 1'b0));
    step(1'b0, 1'b0, 16'h1300, "reti", 1'b1,
         mk(2'b01, 4'd0, 4'd0, 3'b000, 16'h0000, 3'b101, 2'b10, 1'b1));
    step(1'b0, 1'b0, 16'h4303, "mov_r3_r3", 1'b1, MOV43);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 16'($urandom), "ir_hold", 1'b1, MOV43);
    step(1'b0, 1'b0, 16'h5034, "reload", 1'b1, ADD);
    step(1'b1, 1'b1, 16'h4325, "rst_while_hold", 1'b1, RST);
    step(1'b0, 1'b0, 16'h1380, "fmt2_op7_invalid", 1'b1, RST);

    for (int i = 0; i < 400; i++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ;
        1: w = {6'b000100, w[9:0]};
        2: w = {3'b001, w[12:0]};
        default: begin
          hi = 4'($urandom_range(4, 15));
          w = {hi, 3'b001, w[8], w[7:0]};
        end
      endcase
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0), w, "random", 1'b0, RST);
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++)
      @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
